sigmoid_alu_operand_packer: RTL and testbench
=============================================

Name: sigmoid_ALU_operand_packer

Overview:
Transmit-side feeder for the sigmoid ALU 4-way adder. Accepts a serial stream of signed bytes over a valid/ready handshake, groups them four at a time into a registered 4-lane bundle, and presents the bundle on in1..in4-compatible lanes with its own valid/ready handshake. A short final group, marked by in_last, is zero-padded so that the downstream signed sum is unaffected.

Parameters:
DATA_WIDTH, 8, width of each lane and of the input byte (signed two's complement)

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  synchronous active-low reset
in_data  input  DATA_WIDTH  signed operand byte
in_valid  input  1  in_data valid
in_last  input  1  byte is final of its group; qualified by in_valid
in_ready  output  1  packer accepts a byte this cycle
out1  output  DATA_WIDTH  lane 1: first byte of the bundle
out2  output  DATA_WIDTH  lane 2
out3  output  DATA_WIDTH  lane 3
out4  output  DATA_WIDTH  lane 4: fourth byte of the bundle
out_count  output  3  number of real lanes in bundle, 1..4
out_last  output  1  bundle was closed by in_last
out_valid  output  1  bundle valid
out_ready  input  1  consumer accepts bundle

Behaviour:
- Reset (n_rst low at rising edge): state=COLLECT, lane index=0, collector lanes=0, out1..out4=0, out_count=0, out_last=0, out_valid=0. Partial groups and undelivered bundles are discarded. Reset overrides all other events in the same cycle.
- Input handshake: a byte is accepted when in_valid && in_ready. in_ready = (state==COLLECT); it is registered-state only and never depends on in_valid, in_last, or in_data.
- Collector: the accepted byte is written to collector lane[idx]. The group closes when idx==3 or in_last==1. Otherwise idx increments.
- Output slot free condition: free = !out_valid || out_ready.
- On group close with free=1: at the same edge, the output registers load the collector including the new byte. Lanes above idx load 0. out_count=idx+1, out_last=in_last, out_valid=1. idx returns to 0 and state stays COLLECT. Latency is 1 cycle from the closing byte to out_valid. Sustained throughput is 1 byte/cycle with out_ready held high.
- On group close with free=0: state becomes HOLD. The collector keeps the complete group with its zero padding, count, and last flag, and in_ready drops.
- HOLD: on the first cycle with free=1, the held group transfers to the output registers, state returns to COLLECT, and idx=0. in_ready goes high the cycle after the transfer.
- Output handshake: the bundle completes when out_valid && out_ready. out1..out4, out_count, and out_last are stable while out_valid=1 && out_ready=0.
- Simultaneous events: a bundle drain (out_ready=1) coinciding with a group close is a direct transfer, with no bubble. When a drain occurs with no group close, out_valid goes to 0 next cycle.
- in_last at idx==3 behaves as a full group with out_last=1 and out_count=4.
- Lanes carry raw signed bytes with no arithmetic. Zero padding is numerically neutral for the downstream signed 10-bit sum.
- in_valid while in_ready=0 has no effect, and the data is not sampled.

Optional Feature:
Macro SIGMOID_PACKER_SUM_EN.
- When defined: adds output port out_sum [DATA_WIDTH+1:0]. It carries the signed sum of the four lanes and is registered with the bundle, with the same valid and stability rules as out1..out4. It resets to 0. Used as an in-line reference for the adder.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then stream 0x01,0x02,0x03,0x04 with out_ready=1: one cycle after the 4th byte, out1..4 = 01,02,03,04, out_count=4, out_last=0, out_valid=1 for 1 cycle. in_ready stays 1 throughout.
- Stream 0x7F,0x80 with in_last on 0x80: out1=7F, out2=80, out3=out4=00, out_count=2, out_last=1. With SIGMOID_PACKER_SUM_EN, out_sum=10'h3FF (-1).
- Backpressure: out_ready=0, send 8 bytes 0x10..0x17. The first bundle 10..13 is held stable. After 4 more bytes in_ready=0 (HOLD). Raise out_ready for 1 cycle: out1..4 becomes 14..17 at the next edge and in_ready returns to 1 a cycle later. No byte is lost or duplicated.
- Continuous 1 byte/cycle with out_ready=1 for 64 bytes: 16 bundles arrive, in_ready is never 0, and each bundle's out_valid is exactly 1 cycle.
- Assert n_rst=0 after 2 bytes of a group and while a bundle is stalled: next cycle out_valid=0, outputs=0, in_ready=1. The next 4 bytes 0xFF,0xFE,0xFD,0xFC form a fresh bundle in lanes 1..4.
- A single byte 0x80 with in_last gives out_count=1, out1=80, other lanes 00. With SIGMOID_PACKER_SUM_EN, out_sum=10'h380 (-128).

Source files
------------

// File: rtl/sigmoid_alu_operand_packer.sv
// Packs a valid/ready stream of signed bytes into 4-lane bundles for the sigmoid ALU adder.
// Optional SIGMOID_PACKER_SUM_EN adds out_sum, a registered signed sum of the four lanes.
module sigmoid_alu_operand_packer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [2:0]            out_count,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SIGMOID_PACKER_SUM_EN
  ,
  output logic [DATA_WIDTH+1:0] out_sum
`endif
);

  localparam int unsigned LANES = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SUM_W = DATA_WIDTH + 2;

  typedef struct packed {
    logic [LANES-1:0][DATA_WIDTH-1:0] lane;
    logic [CNT_W-1:0]                 count;
    logic                             last;
  } bundle_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  bundle_t          col;
  bundle_t          out_q;
  bundle_t          new_grp;
  logic             accept;
  logic             close_grp;
  logic             free;

  assign accept    = in_valid && in_ready;
  assign close_grp = accept && ((idx == IDX_W'(LANES - 1)) || in_last);
  assign free      = !out_valid || out_ready;

  // Closing group: lanes already collected, the incoming byte at idx, zeros above.
  always_comb begin
    new_grp = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (IDX_W'(i) < idx) begin
        new_grp.lane[i] = col.lane[i];
      end else if (IDX_W'(i) == idx) begin
        new_grp.lane[i] = in_data;
      end
    end
    new_grp.count = CNT_W'(idx) + CNT_W'(1);
    new_grp.last  = in_last;
  end

`ifdef SIGMOID_PACKER_SUM_EN
  function automatic logic [SUM_W-1:0] lane_sum(input bundle_t b);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      acc = acc + {{(SUM_W - DATA_WIDTH){b.lane[i][DATA_WIDTH-1]}}, b.lane[i]};
    end
    return acc;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= COLLECT;
      idx       <= '0;
      col       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SIGMOID_PACKER_SUM_EN
      out_sum   <= '0;
`endif
    end else begin
      // A drain clears valid unless a new bundle loads at the same edge below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        COLLECT: begin
          if (accept) begin
            if (close_grp) begin
              idx <= '0;
              if (free) begin
                out_q     <= new_grp;
                out_valid <= 1'b1;
`ifdef SIGMOID_PACKER_SUM_EN
                out_sum   <= lane_sum(new_grp);
`endif
              end else begin
                col      <= new_grp;
                state    <= HOLD;
                in_ready <= 1'b0;
              end
            end else begin
              col.lane[idx] <= in_data;
              idx           <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (free) begin
            out_q     <= col;
            out_valid <= 1'b1;
            state     <= COLLECT;
            in_ready  <= 1'b1;
`ifdef SIGMOID_PACKER_SUM_EN
            out_sum   <= lane_sum(col);
`endif
          end
        end
        default: begin
          state    <= COLLECT;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out1      = out_q.lane[0];
  assign out2      = out_q.lane[1];
  assign out3      = out_q.lane[2];
  assign out4      = out_q.lane[3];
  assign out_count = out_q.count;
  assign out_last  = out_q.last;

endmodule

// File: tb/tb_sigmoid_alu_operand_packer.sv
// Scoreboard bench for sigmoid_alu_operand_packer: directed groups, backpressure, streaming, reset.
module tb_sigmoid_alu_operand_packer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out1, out2, out3, out4;
  logic [2:0]   out_count;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
`ifdef SIGMOID_PACKER_SUM_EN
  logic [W+1:0] out_sum;
`endif

  always #5 clk = ~clk;

  sigmoid_alu_operand_packer #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SIGMOID_PACKER_SUM_EN
    ,
    .out_sum   (out_sum)
`endif
  );

  typedef struct packed {
    logic [7:0] l1, l2, l3, l4;
    logic [2:0] cnt;
    logic       last;
    logic [9:0] sum;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   bundles_seen = 0;
  bit   chk_stream = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [2:0] cnt, input logic last,
                      input logic [9:0] sum);
    exp_t e;
    e.l1 = a; e.l2 = b; e.l3 = c; e.l4 = d;
    e.cnt = cnt; e.last = last; e.sum = sum;
    exp_q.push_back(e);
  endtask

  // Drive one byte until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    int   n;
    logic r;
    bit   done;
    n = 0;
    done = 1'b0;
    in_data = d; in_valid = 1'b1; in_last = last;
    while (!done) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          tests++; fails++;
          $display("FAIL send_timeout: byte %0h not accepted, required acceptance", d);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Monitor: pops and compares each bundle at the handshake.
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_bundle: got %0h %0h %0h %0h, required none", out1, out2, out3, out4);
      end else begin
        mon_e = exp_q.pop_front();
        check("lane1", 32'(out1), 32'(mon_e.l1));
        check("lane2", 32'(out2), 32'(mon_e.l2));
        check("lane3", 32'(out3), 32'(mon_e.l3));
        check("lane4", 32'(out4), 32'(mon_e.l4));
        check("count", 32'(out_count), 32'(mon_e.cnt));
        check("last", 32'(out_last), 32'(mon_e.last));
`ifdef SIGMOID_PACKER_SUM_EN
        check("sum", 32'(out_sum), 32'(mon_e.sum));
`endif
        bundles_seen++;
      end
    end
    if (chk_stream) begin
      check("in_ready_stream", 32'(in_ready), 32'd1);
      if (out_valid) check("valid_one_cycle", 32'(prev_valid), 32'd0);
    end
    prev_valid = out_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_lanes", {out1, out2, out3, out4}, 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Full group, 1-cycle latency.
    out_ready = 1'b1;
    chk_stream = 1'b1;
    push(8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 1'b0, 10'h00A);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    @(negedge clk);
    check("t1_latency", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk_stream = 1'b0;

    // Short group padded, then a single-byte group.
    push(8'h7F, 8'h80, 8'h00, 8'h00, 3'd2, 1'b1, 10'h3FF);
    send(8'h7F, 1'b0); send(8'h80, 1'b1);
    push(8'h80, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 10'h380);
    send(8'h80, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Backpressure: second group parks in HOLD.
    out_ready = 1'b0;
    push(8'h10, 8'h11, 8'h12, 8'h13, 3'd4, 1'b0, 10'h046);
    push(8'h14, 8'h15, 8'h16, 8'h17, 3'd4, 1'b0, 10'h056);
    for (int k = 0; k < 8; k++) send(8'(8'h10 + k), 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_stable", {out1, out2, out3, out4}, 32'h10111213);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("hold_xfer", {out1, out2, out3, out4}, 32'h14151617);
    check("hold_xfer_valid", 32'(out_valid), 32'd1);
    check("hold_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Sustained stream: 64 bytes, 16 bundles.
    bundles_seen = 0;
    chk_stream = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k % 4 == 0)
        push(8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3), 3'd4, 1'b0, 10'(16 * (k / 4) + 6));
      send(8'(k), 1'b0);
    end
    @(posedge clk); #1;
    chk_stream = 1'b0;
    check("stream_bundles", 32'(bundles_seen), 32'd16);

    // Reset with a stalled bundle and a partial group.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(8'(8'h20 + k), 1'b0);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_lanes", {out1, out2, out3, out4}, 32'd0);
    check("rst2_count", 32'(out_count), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(8'hFF, 8'hFE, 8'hFD, 8'hFC, 3'd4, 1'b0, 10'h3F6);
    send(8'hFF, 1'b0); send(8'hFE, 1'b0); send(8'hFD, 1'b0); send(8'hFC, 1'b0);

    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
